// File: rtl/rr_grant_if.sv
// rr_grant_if: request/grant bundle between four requesters and the
// round-robin grant controller.
//
// Signals:
//   req       [3:0]  request lines, one per requester
//   gnt       [3:0]  one-hot grant vector (0000 when no grant is active)
//   gnt_idx   [1:0]  index of the current grant, or of the last one when idle
//   gnt_valid        high while a grant is active
//   timeout          one-cycle pulse after a grant is revoked by the hold limit
//
// Modports:
//   master  requester side: drives req, observes the grant outputs
//   slave   arbiter side: observes req, drives the grant outputs
interface rr_grant_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  modport master (
    output req,
    input  gnt,
    input  gnt_idx,
    input  gnt_valid,
    input  timeout
  );

  modport slave (
    input  req,
    output gnt,
    output gnt_idx,
    output gnt_valid,
    output timeout
  );
endinterface

// File: rtl/rr_grant_controller.sv
// rr_grant_controller: four-requester round-robin arbiter for one shared
// resource. A grant is held while its owner keeps requesting, up to MAX_HOLD
// consecutive cycles (0 = unlimited). Every release is followed by one dead
// cycle with no grant so the shared bus can turn around.
//
// Parameters:
//   MAX_HOLD  maximum consecutive grant cycles, 0..255; 0 disables the limit
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    rr_grant_if.slave: req in; gnt, gnt_idx, gnt_valid, timeout out
//
// All outputs come straight from flops; req never reaches gnt combinationally.
module rr_grant_controller #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  rr_grant_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam logic [7:0] HOLD_LIMIT = MAX_HOLD[7:0];
  localparam bit         HOLD_EN    = (MAX_HOLD != 0);

  state_e     state_q, state_d;
  logic [7:0] hold_q, hold_d;
  logic [1:0] last_q, last_d;
  logic [1:0] idx_q, idx_d;
  logic       timeout_q, timeout_d;
  logic [3:0] gnt_q, gnt_d;

  logic [3:0] rot_req;     // req rotated so bit 0 is requester last+1
  logic [1:0] pick_off;    // offset of the first set bit in rot_req
  logic [1:0] pick_idx;    // absolute index of the winning requester
  logic       req_any;
  logic       owner_req;
  logic       hold_hit;
  logic [3:0] idx_onehot;  // 2-to-4 decode of the next grant index

  // Rotation: rot_req[k] is requester (last+1+k) mod 4, so scanning rot_req
  // from bit 0 upward visits last+1, last+2, last+3, last.
  for (genvar gi = 0; gi < 4; gi++) begin : g_rotate
    assign rot_req[gi] = bus.req[last_q + 2'(gi + 1)];
  end

  always_comb begin
    pick_off = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (rot_req[i]) begin
        pick_off = 2'(i);
      end
    end
  end

  assign pick_idx  = last_q + pick_off + 2'd1;
  assign req_any   = |bus.req;
  assign owner_req = bus.req[idx_q];
  assign hold_hit  = HOLD_EN && (hold_q == HOLD_LIMIT);

  // State register (all flops, cleared asynchronously)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      hold_q    <= 8'd0;
      last_q    <= 2'd3;  // requester 0 wins the first arbitration
      idx_q     <= 2'd0;
      timeout_q <= 1'b0;
      gnt_q     <= 4'b0000;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      last_q    <= last_d;
      idx_q     <= idx_d;
      timeout_q <= timeout_d;
      gnt_q     <= gnt_d;
    end
  end

  // Next-state logic. A release (normal or forced) always lands in IDLE,
  // which provides the mandatory dead cycle before the next grant.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_any) begin
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!owner_req || hold_hit) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath logic. The owner dropping req takes precedence over the
  // hold limit, so a coincident drop is a normal release with no timeout.
  always_comb begin
    hold_d    = hold_q;
    last_d    = last_q;
    idx_d     = idx_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_any) begin
          idx_d  = pick_idx;
          last_d = pick_idx;
          hold_d = 8'd1;
        end
      end
      BUSY: begin
        if (!owner_req) begin
          hold_d = 8'd0;
        end else if (hold_hit) begin
          timeout_d = 1'b1;
          hold_d    = 8'd0;
        end else if (hold_q != 8'hFF) begin
          hold_d = hold_q + 8'd1;  // saturate so MAX_HOLD=0 never wraps
        end
      end
      default: begin
        hold_d = 8'd0;
      end
    endcase
    gnt_d = (state_d == BUSY) ? idx_onehot : 4'b0000;
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_decode
    assign idx_onehot[gi] = (idx_d == 2'(gi));
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = idx_q;
  assign bus.gnt_valid = (state_q == BUSY);
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_rr_grant_controller.sv
// tb_rr_grant_controller: three controllers (MAX_HOLD = 16, 4, 0) share one
// clock, reset and request vector; each stimulus record names the instance
// whose outputs are compared.
module tb_rr_grant_controller;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       valid;
    logic       to;
  } out_t;

  typedef struct {
    bit         pre_rst;
    int         sel;
    logic [3:0] req;
    out_t       exp;
    string      tag;
  } vec_t;

  typedef struct {
    int    sel;
    out_t  exp;
    string tag;
  } sb_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req_drv = 4'b0000;

  int errors = 0;
  int checks = 0;

  vec_t vecs[$];
  sb_t  sb[$];
  out_t act [3];

  always #5 clk = ~clk;

  rr_grant_if bus_a ();
  rr_grant_if bus_b ();
  rr_grant_if bus_c ();

  assign bus_a.req = req_drv;
  assign bus_b.req = req_drv;
  assign bus_c.req = req_drv;

  rr_grant_controller #(.MAX_HOLD(16)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  rr_grant_controller #(.MAX_HOLD(4))  dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
  rr_grant_controller #(.MAX_HOLD(0))  dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));

  assign act[0] = {bus_a.gnt, bus_a.gnt_idx, bus_a.gnt_valid, bus_a.timeout};
  assign act[1] = {bus_b.gnt, bus_b.gnt_idx, bus_b.gnt_valid, bus_b.timeout};
  assign act[2] = {bus_c.gnt, bus_c.gnt_idx, bus_c.gnt_valid, bus_c.timeout};

  function automatic out_t o(logic [3:0] g, logic [1:0] i, logic v, logic t);
    out_t r;
    r.gnt = g; r.idx = i; r.valid = v; r.to = t;
    return r;
  endfunction

  function automatic void add(bit pre, int sel, logic [3:0] r, out_t e, string tag);
    vec_t v;
    v.pre_rst = pre; v.sel = sel; v.req = r; v.exp = e; v.tag = tag;
    vecs.push_back(v);
  endfunction

  task automatic check(string name, out_t got, out_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got gnt=%b idx=%0d valid=%b timeout=%b, expected gnt=%b idx=%0d valid=%b timeout=%b",
               name, got.gnt, got.idx, got.valid, got.to, exp.gnt, exp.idx, exp.valid, exp.to);
    end else begin
      $display("ok   %s: gnt=%b idx=%0d valid=%b timeout=%b", name, got.gnt, got.idx, got.valid, got.to);
    end
  endtask

  // Drive now (caller is already just past a falling edge), push the expected
  // result, then pop and compare once the DUT has registered it.
  task automatic apply(int sel, logic [3:0] r, out_t e, string tag);
    sb_t s;
    req_drv = r;
    s.sel = sel; s.exp = e; s.tag = tag;
    sb.push_back(s);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, expected one pending entry", tag);
    end else begin
      s = sb.pop_front();
      check(s.tag, act[s.sel], s.exp);
    end
  endtask

  task automatic drive(int sel, logic [3:0] r, out_t e, string tag);
    @(negedge clk);
    apply(sel, r, e, tag);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    req_drv = 4'b0000;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- stimulus table ----------------
    // Single requester 2, three cycles, then release
    for (int i = 0; i < 3; i++) add(i == 0, 0, 4'b0100, o(4'b0100, 2, 1, 0), "single_gnt");
    add(0, 0, 4'b0000, o(4'b0000, 2, 0, 0), "single_rel");
    add(0, 0, 4'b0000, o(4'b0000, 2, 0, 0), "single_idle");

    // Rotation: each owner drops req for one cycle after two granted cycles
    add(1, 0, 4'b1111, o(4'b0001, 0, 1, 0), "rot_g0");
    add(0, 0, 4'b1111, o(4'b0001, 0, 1, 0), "rot_g0");
    add(0, 0, 4'b1110, o(4'b0000, 0, 0, 0), "rot_dead");
    add(0, 0, 4'b1111, o(4'b0010, 1, 1, 0), "rot_g1");
    add(0, 0, 4'b1111, o(4'b0010, 1, 1, 0), "rot_g1");
    add(0, 0, 4'b1101, o(4'b0000, 1, 0, 0), "rot_dead");
    add(0, 0, 4'b1111, o(4'b0100, 2, 1, 0), "rot_g2");
    add(0, 0, 4'b1111, o(4'b0100, 2, 1, 0), "rot_g2");
    add(0, 0, 4'b1011, o(4'b0000, 2, 0, 0), "rot_dead");
    add(0, 0, 4'b1111, o(4'b1000, 3, 1, 0), "rot_g3");
    add(0, 0, 4'b1111, o(4'b1000, 3, 1, 0), "rot_g3");
    add(0, 0, 4'b0111, o(4'b0000, 3, 0, 0), "rot_dead");
    add(0, 0, 4'b1111, o(4'b0001, 0, 1, 0), "rot_wrap_g0");
    add(0, 0, 4'b0000, o(4'b0000, 0, 0, 0), "rot_rel");

    // Timeout with MAX_HOLD=4, two requesters held constantly
    for (int i = 0; i < 4; i++) add(i == 0, 1, 4'b0011, o(4'b0001, 0, 1, 0), "to_g0");
    add(0, 1, 4'b0011, o(4'b0000, 0, 0, 1), "to_dead0");
    for (int i = 0; i < 4; i++) add(0, 1, 4'b0011, o(4'b0010, 1, 1, 0), "to_g1");
    add(0, 1, 4'b0011, o(4'b0000, 1, 0, 1), "to_dead1");
    add(0, 1, 4'b0011, o(4'b0001, 0, 1, 0), "to_regrant0");
    add(0, 1, 4'b0000, o(4'b0000, 0, 0, 0), "to_rel");

    // Owner drops req on the edge where the hold count reaches 4
    for (int i = 0; i < 4; i++) add(i == 0, 1, 4'b0001, o(4'b0001, 0, 1, 0), "coin_g0");
    add(0, 1, 4'b0000, o(4'b0000, 0, 0, 0), "coin_rel");
    add(0, 1, 4'b0000, o(4'b0000, 0, 0, 0), "coin_idle");

    // Sole requester times out and is re-granted after the dead cycle
    for (int i = 0; i < 4; i++) add(i == 0, 1, 4'b0001, o(4'b0001, 0, 1, 0), "sole_g0");
    add(0, 1, 4'b0001, o(4'b0000, 0, 0, 1), "sole_dead");
    add(0, 1, 4'b0001, o(4'b0001, 0, 1, 0), "sole_regrant");
    add(0, 1, 4'b0000, o(4'b0000, 0, 0, 0), "sole_rel");

    // ---------------- reset behaviour ----------------
    rst_n = 1'b0;
    req_drv = 4'b1111;
    #12;
    check("rst_a", act[0], o(4'b0000, 0, 0, 0));
    check("rst_b", act[1], o(4'b0000, 0, 0, 0));
    check("rst_c", act[2], o(4'b0000, 0, 0, 0));
    @(posedge clk);
    #1;
    check("rst_held_edge", act[0], o(4'b0000, 0, 0, 0));

    @(negedge clk);
    rst_n = 1'b1;
    apply(0, 4'b1111, o(4'b0001, 0, 1, 0), "rst_release_g0");
    drive(0, 4'b1111, o(4'b0001, 0, 1, 0), "rst_hold_g0");
    #1;
    rst_n = 1'b0;
    #1;
    check("async_clear_a", act[0], o(4'b0000, 0, 0, 0));
    check("async_clear_b", act[1], o(4'b0000, 0, 0, 0));
    @(negedge clk);
    req_drv = 4'b0000;
    rst_n = 1'b1;

    // ---------------- table-driven vectors ----------------
    foreach (vecs[k]) begin
      if (vecs[k].pre_rst) pulse_reset();
      drive(vecs[k].sel, vecs[k].req, vecs[k].exp, vecs[k].tag);
    end

    // ---------------- MAX_HOLD=0: no limit, counter saturates ----------------
    pulse_reset();
    for (int i = 0; i < 300; i++) begin
      drive(2, 4'b1000, o(4'b1000, 3, 1, 0), $sformatf("nolimit_%0d", i));
    end
    drive(2, 4'b0000, o(4'b0000, 3, 0, 0), "nolimit_rel");

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_grant_controller.md
Name: rr_grant_controller

Overview:
- Four-requester round-robin arbiter for one shared resource.
- Internally drives a 2-to-4 decode of a registered grant index to produce the one-hot grant vector.
- Grants are held while the owner keeps requesting, up to a programmable hold limit.
- Sits in front of the shared datapath; each requester gates its access with its own grant bit.

Parameters:
- MAX_HOLD, default 16: maximum consecutive cycles one grant may be held. Range 0..255; 0 disables the limit.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  4  request lines; req[i] high means requester i wants the resource.
- gnt  output  4  one-hot grant, equal to decode(gnt_idx) while gnt_valid=1; otherwise 0000.
- gnt_idx  output  2  index of the current grant, or of the last grant when gnt_valid=0.
- gnt_valid  output  1  high while any grant is active.
- timeout  output  1  one-cycle pulse when a grant is forcibly revoked by the hold limit.

Behaviour:
- Reset: one clock, clk; reset is asynchronous active-low on rst_n.
  - While rst_n=0, immediately: gnt=0000, gnt_idx=0, gnt_valid=0, timeout=0, state=IDLE, hold counter=0, last pointer=3 (so requester 0 has top priority after reset).
  - Reset asserted mid-grant clears gnt in the same cycle, without waiting for a clock edge.
- All outputs are registered; there is no combinational path from req to gnt.
- State IDLE: gnt_valid=0.
  - At a rising edge with req != 0000: select the first set bit in the order last+1, last+2, last+3, last (mod 4).
  - Load gnt_idx, set gnt_valid=1, set last=selected index, set hold counter=1, go to BUSY.
  - With req=0000: stay in IDLE.
  - Latency: req sampled at edge k gives gnt visible after edge k.
- State BUSY: at each edge, evaluate in priority order:
  - (a) req[gnt_idx]=0: release. Go to IDLE, gnt_valid=0, timeout=0.
  - (b) MAX_HOLD!=0, hold counter==MAX_HOLD, and req[gnt_idx]=1: forced release. Go to IDLE, gnt_valid=0, timeout=1 for exactly one cycle.
  - (c) otherwise: stay in BUSY and increment the hold counter, saturating at 255.
  - Requests from non-owners during BUSY are ignored; they compete at the next arbitration.
- Every release is followed by at least one dead cycle (gnt=0000) for bus turnaround. Consecutive grants are therefore separated by exactly one idle cycle when requests are pending.
- Boundary cases:
  - Owner drops req on the same edge the counter hits MAX_HOLD: normal release, timeout stays 0.
  - With MAX_HOLD=N, a continuously requesting owner holds gnt for exactly N cycles.
  - A timed-out requester becomes lowest priority (last=its index). If it is the only requester, it is re-granted after the dead cycle.
  - Priority pointer wraps 3 -> 0.
  - gnt is never multi-hot. gnt_idx retains its value in IDLE.
  - timeout is 0 in every cycle except the one following a forced release.

Test Plan:
- Reset: drive rst_n=0 with req=1111 -> gnt=0000, gnt_valid=0, timeout=0. Release reset with req=1111 -> after first edge gnt=0001, gnt_idx=0. Assert rst_n=0 mid-grant -> gnt=0000 immediately, before the next edge.
- Single requester: req=0100 held 3 cycles, then 0000 -> gnt=0100, gnt_idx=2 for 3 cycles, then gnt=0000, gnt_valid=0; timeout never asserts.
- Rotation: all four requesters request; each drops req for one cycle after 2 granted cycles, then re-requests -> grant order 0001, 0010, 0100, 1000, 0001, with one 0000 cycle between grants.
- Timeout (MAX_HOLD=4): req=0011 held constantly -> gnt=0001 for 4 cycles; dead cycle with timeout=1; gnt=0010 for 4 cycles; dead cycle with timeout=1; gnt=0001 again.
- Edge coincidence (MAX_HOLD=4): req=0001 dropped on the edge where the hold count reaches 4 -> 4 grant cycles, timeout stays 0.
- MAX_HOLD=0: req=1000 held 300 cycles -> gnt=1000 continuously for 300 cycles (checks counter saturation, no wrap); timeout stays 0.
